// File: rtl/interrupt_controller_if.sv
// CPU/peripheral-facing bundle of the interrupt controller: request pulses,
// register access, instruction-boundary info and the dispatch handshake.
interface interrupt_controller_if;
  logic [7:0] iOpcode;
  logic       iEof;
  logic       iIrqVBlank;
  logic       iIrqStat;
  logic       iIrqTimer;
  logic       iIrqSerial;
  logic       iIrqJoypad;
  logic       iMcuWe;
  logic [3:0] iMcuRegSelect;
  logic       iIeWe;
  logic [7:0] iMcuWriteData;
  logic       iIntAck;
  logic [7:0] oIf;
  logic [7:0] oIe;
  logic       oIme;
  logic       oInterrupt;
  logic [7:0] oVector;
  logic       oWake;

  modport master (
    output iOpcode, iEof, iIrqVBlank, iIrqStat, iIrqTimer, iIrqSerial,
           iIrqJoypad, iMcuWe, iMcuRegSelect, iIeWe, iMcuWriteData, iIntAck,
    input  oIf, oIe, oIme, oInterrupt, oVector, oWake
  );

  modport slave (
    input  iOpcode, iEof, iIrqVBlank, iIrqStat, iIrqTimer, iIrqSerial,
           iIrqJoypad, iMcuWe, iMcuRegSelect, iIeWe, iMcuWriteData, iIntAck,
    output oIf, oIe, oIme, oInterrupt, oVector, oWake
  );
endinterface

// File: rtl/interrupt_controller.sv
// Game Boy interrupt controller: owns IF/IE/IME and dispatches the highest
// priority enabled pending source to the CPU at instruction boundaries.
module interrupt_controller (
  input  logic                   iClock,
  input  logic                   iReset,
  interrupt_controller_if.slave  bus
);

  localparam logic [7:0] OP_DI   = 8'hF3;
  localparam logic [7:0] OP_EI   = 8'hFB;
  localparam logic [7:0] OP_RETI = 8'hD9;

  typedef enum logic {S_IDLE, S_DISPATCH} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_if;
  logic [7:0] r_ie;
  logic       r_ime;
  logic       r_ei_pend;
  logic [7:0] r_vector;

  logic [4:0] w_pending;
  logic [4:0] w_pulses;
  logic [2:0] w_idx;
  logic [4:0] w_clear;
  logic [4:0] w_if_base;
  logic       w_eff_ime;
  logic       w_dispatch;
  logic       w_is_di;
  logic       w_is_ei;
  logic       w_is_reti;

  assign w_pending = r_ie[4:0] & r_if;
  assign w_pulses  = {bus.iIrqJoypad, bus.iIrqSerial, bus.iIrqTimer,
                      bus.iIrqStat, bus.iIrqVBlank};
  assign w_is_di   = (bus.iOpcode == OP_DI);
  assign w_is_ei   = (bus.iOpcode == OP_EI);
  assign w_is_reti = (bus.iOpcode == OP_RETI);

  // IME as seen by the instruction that is just completing
  always_comb begin
    w_eff_ime = r_ime;
    if (w_is_di || w_is_ei)
      w_eff_ime = 1'b0;
    else if (w_is_reti || r_ei_pend)
      w_eff_ime = 1'b1;
  end

  // Descending scan so the lowest set bit (VBlank first) wins
  always_comb begin
    w_idx = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (w_pending[i]) w_idx = i[2:0];
  end

  assign w_dispatch = (r_state == S_IDLE) && bus.iEof && w_eff_ime && (|w_pending);
  assign w_clear    = w_dispatch ? (5'b00001 << w_idx) : 5'b00000;
  assign w_if_base  = (bus.iMcuWe && bus.iMcuRegSelect == 4'hF) ?
                      bus.iMcuWriteData[4:0] : r_if;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_if      <= 5'd0;
      r_ie      <= 8'd0;
      r_ime     <= 1'b0;
      r_ei_pend <= 1'b0;
    end else begin
      // Request pulses are OR'd last so they beat a same-cycle write or clear
      r_if <= (w_if_base & ~w_clear) | w_pulses;
      if (bus.iIeWe)
        r_ie <= bus.iMcuWriteData;
      if (w_dispatch) begin
        r_ime     <= 1'b0;
        r_ei_pend <= 1'b0;
      end else if (bus.iEof) begin
        if (w_is_di) begin
          r_ime     <= 1'b0;
          r_ei_pend <= 1'b0;
        end else if (w_is_ei) begin
          r_ei_pend <= 1'b1;
        end else if (w_is_reti) begin
          r_ime <= 1'b1;
        end else if (r_ei_pend) begin
          r_ime     <= 1'b1;
          r_ei_pend <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (w_dispatch)
      r_vector <= 8'h40 + {2'b00, w_idx, 3'b000};
  end

  always_ff @(posedge iClock) begin
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_dispatch) w_next = S_DISPATCH;
      S_DISPATCH: if (bus.iIntAck) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.oInterrupt = 1'b0;
    bus.oVector    = 8'h00;
    if (r_state == S_DISPATCH) begin
      bus.oInterrupt = 1'b1;
      bus.oVector    = r_vector;
    end
  end

  assign bus.oIf   = {3'b111, r_if};
  assign bus.oIe   = r_ie;
  assign bus.oIme  = r_ime;
  assign bus.oWake = |w_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a behavioural reference model
// checked every cycle plus literal expectations at key points.
module tb_interrupt_controller;

  logic iClock = 1'b0;
  logic iReset = 1'b0;
  interrupt_controller_if bus();

  interrupt_controller dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus.slave)
  );

  always #5 iClock = ~iClock;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int m_if, m_ie, m_ime, m_pend, m_busy, m_vec;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge iClock) begin : model
    int pend_bits, eff, idx, nif, pulses;
    if (iReset) begin
      m_if = 0; m_ie = 0; m_ime = 0; m_pend = 0; m_busy = 0; m_vec = 0;
    end else begin
      pend_bits = m_ie & m_if & 32'h1F;
      if (bus.iOpcode == 8'hF3 || bus.iOpcode == 8'hFB) eff = 0;
      else if (bus.iOpcode == 8'hD9 || m_pend != 0)     eff = 1;
      else                                              eff = m_ime;
      pulses = {27'd0, bus.iIrqJoypad, bus.iIrqSerial, bus.iIrqTimer,
                bus.iIrqStat, bus.iIrqVBlank};
      nif = (bus.iMcuWe && bus.iMcuRegSelect == 4'hF) ? (bus.iMcuWriteData & 8'h1F) : m_if;
      if (m_busy == 0 && bus.iEof && eff == 1 && pend_bits != 0) begin
        idx = 0;
        while (((pend_bits >> idx) & 1) == 0) idx++;
        nif   = nif & ~(1 << idx);
        m_vec = 64 + 8 * idx;
        m_busy = 1; m_ime = 0; m_pend = 0;
      end else begin
        if (m_busy == 1 && bus.iIntAck) m_busy = 0;
        if (bus.iEof) begin
          case (bus.iOpcode)
            8'hF3: begin m_ime = 0; m_pend = 0; end
            8'hFB: m_pend = 1;
            8'hD9: m_ime = 1;
            default: if (m_pend != 0) begin m_ime = 1; m_pend = 0; end
          endcase
        end
      end
      m_if = nif | pulses;
      if (bus.iIeWe) m_ie = bus.iMcuWriteData;
    end
  end

  always @(negedge iClock) begin : compare
    if (chk_en) begin
      check("model_oIf",        bus.oIf,        32'hE0 | m_if);
      check("model_oIe",        bus.oIe,        m_ie);
      check("model_oIme",       bus.oIme,       m_ime);
      check("model_oInterrupt", bus.oInterrupt, m_busy);
      check("model_oVector",    bus.oVector,    m_busy ? m_vec : 0);
      check("model_oWake",      bus.oWake,      ((m_ie & m_if & 32'h1F) != 0) ? 1 : 0);
    end
  end

  task automatic clear_inputs();
    bus.iEof = 0; bus.iOpcode = 8'h00;
    bus.iIrqVBlank = 0; bus.iIrqStat = 0; bus.iIrqTimer = 0;
    bus.iIrqSerial = 0; bus.iIrqJoypad = 0;
    bus.iMcuWe = 0; bus.iMcuRegSelect = 4'h0; bus.iIeWe = 0;
    bus.iMcuWriteData = 8'h00; bus.iIntAck = 0;
  endtask

  task automatic tick();
    @(posedge iClock);
    @(negedge iClock);
    clear_inputs();
  endtask

  task automatic boundary(input logic [7:0] op);
    bus.iEof = 1; bus.iOpcode = op; tick();
  endtask

  task automatic write_ie(input logic [7:0] v);
    bus.iIeWe = 1; bus.iMcuWriteData = v; tick();
  endtask

  task automatic write_if(input logic [7:0] v);
    bus.iMcuWe = 1; bus.iMcuRegSelect = 4'hF; bus.iMcuWriteData = v; tick();
  endtask

  task automatic ack();
    bus.iIntAck = 1; tick();
  endtask

  initial begin
    clear_inputs();
    @(negedge iClock);
    iReset = 1; tick(); tick(); iReset = 0;
    chk_en = 1'b1;
    check("rst_oIf", bus.oIf, 8'hE0);
    check("rst_oIe", bus.oIe, 8'h00);
    check("rst_oIme", bus.oIme, 0);
    check("rst_oInterrupt", bus.oInterrupt, 0);
    check("rst_oVector", bus.oVector, 8'h00);
    check("rst_oWake", bus.oWake, 0);

    // Timer dispatch
    write_ie(8'h04);
    check("ie_write", bus.oIe, 8'h04);
    boundary(8'hFB);
    check("ei_ime_still0", bus.oIme, 0);
    boundary(8'h00);
    check("ei_nop_ime1", bus.oIme, 1);
    bus.iIrqTimer = 1; tick();
    check("timer_oIf", bus.oIf, 8'hE4);
    check("timer_wake", bus.oWake, 1);
    boundary(8'h00);
    check("timer_int", bus.oInterrupt, 1);
    check("timer_vec", bus.oVector, 8'h50);
    check("timer_if_clr", bus.oIf, 8'hE0);
    check("timer_ime0", bus.oIme, 0);
    tick(); tick();
    check("timer_hold", bus.oInterrupt, 1);
    ack();
    check("ack_int", bus.oInterrupt, 0);
    check("ack_vec", bus.oVector, 8'h00);
    ack();
    check("idle_ack_ignored", bus.oInterrupt, 0);

    // Priority: VBlank before Joypad, Joypad dispatched at RETI boundary
    write_ie(8'h1F);
    boundary(8'hD9);
    check("reti_ime1", bus.oIme, 1);
    bus.iIrqVBlank = 1; bus.iIrqJoypad = 1; tick();
    check("two_pend_if", bus.oIf, 8'hF1);
    boundary(8'h00);
    check("prio_vec40", bus.oVector, 8'h40);
    check("prio_if_left", bus.oIf, 8'hF0);
    boundary(8'hD9);
    check("dispatch_ignores_eof", bus.oVector, 8'h40);
    ack();
    boundary(8'hD9);
    check("reti_vec60", bus.oVector, 8'h60);
    check("reti_int", bus.oInterrupt, 1);
    ack();

    // EI boundary delays dispatch by one boundary
    bus.iIrqTimer = 1; tick();
    boundary(8'hFB);
    check("ei_no_dispatch", bus.oInterrupt, 0);
    boundary(8'h00);
    check("ei_next_dispatch", bus.oVector, 8'h50);
    ack();

    // EI then DI never enables
    bus.iIrqStat = 1; tick();
    boundary(8'hFB);
    boundary(8'hF3);
    check("ei_di_ime", bus.oIme, 0);
    boundary(8'h00);
    check("ei_di_no_int", bus.oInterrupt, 0);
    check("ei_di_ime_after", bus.oIme, 0);
    check("ei_di_if", bus.oIf, 8'hE2);

    // Pulse beats same-cycle IF write
    bus.iMcuWe = 1; bus.iMcuRegSelect = 4'hF; bus.iMcuWriteData = 8'h00;
    bus.iIrqSerial = 1; tick();
    check("pulse_vs_write", bus.oIf, 8'hE8);

    // Wake without IME
    write_if(8'h00);
    write_ie(8'h01);
    bus.iIrqVBlank = 1; tick();
    check("wake", bus.oWake, 1);
    boundary(8'h00);
    check("wake_no_int", bus.oInterrupt, 0);

    // Reset while dispatching 0x48
    write_if(8'h00);
    write_ie(8'h02);
    boundary(8'hD9);
    bus.iIrqStat = 1; tick();
    boundary(8'h00);
    check("pre_rst_vec48", bus.oVector, 8'h48);
    iReset = 1; tick(); iReset = 0;
    check("dsp_rst_int", bus.oInterrupt, 0);
    check("dsp_rst_vec", bus.oVector, 8'h00);
    check("dsp_rst_if", bus.oIf, 8'hE0);
    check("dsp_rst_ie", bus.oIe, 8'h00);
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Owns IF (0xFF0F), IE (0xFFFF) and IME, and schedules interrupt dispatch to the CPU for the five Game Boy sources.
- Collects one-cycle request pulses from the PPU, timers, serial and joypad blocks.
- Picks the highest-priority enabled pending source at an instruction boundary and hands its vector to the CPU.
- Clears the serviced IF bit, and sequences EI/DI/RETI effects on IME.

## Interface
- No parameters.
- iClock  in  1  system clock
- iReset  in  1  synchronous, active-high reset
- iOpcode  in  8  opcode of the instruction completing when iEof=1
- iEof  in  1  one-cycle pulse: instruction boundary
- iIrqVBlank, iIrqStat, iIrqTimer, iIrqSerial, iIrqJoypad  in  1 each  request pulses, IF bits 0..4
- iMcuWe  in  1  CPU register write strobe
- iMcuRegSelect  in  4  low nibble of 0xFF0x; 4'hF selects IF
- iIeWe  in  1  CPU write strobe for IE (0xFFFF)
- iMcuWriteData  in  8  write data
- iIntAck  in  1  CPU has pushed PC and jumped to oVector
- oIf  out  8  {3'b111, IF[4:0]}
- oIe  out  8  IE register, all 8 bits stored
- oIme  out  1  master enable
- oInterrupt  out  1  dispatch request to CPU; high from dispatch until acknowledged
- oVector  out  8  0x40/0x48/0x50/0x58/0x60; 0x00 when idle
- oWake  out  1  (IE[4:0] & IF[4:0]) != 0, independent of IME (HALT exit)

## Operation
- IF next value, in this order:
  - base = (iMcuWe & iMcuRegSelect==4'hF) ? iMcuWriteData[4:0] : IF
  - base & ~clearmask
  - OR the request pulses
  - A pulse therefore wins over a same-cycle CPU write or dispatch clear of that bit.
- IE: loaded from iMcuWriteData when iIeWe=1.
- IME register updates, evaluated only on iEof:
  - 0xF3 DI: IME=0, EI-pending cleared.
  - 0xFB EI: EI-pending=1, IME unchanged.
  - 0xD9 RETI: IME=1.
  - Any other opcode with EI-pending=1: IME=1, pending cleared.
  - EI followed by DI: IME never becomes 1.
- Effective IME at a boundary:
  - 0 if opcode is DI or EI.
  - 1 if opcode is RETI, or if EI-pending=1 and opcode is not DI/EI.
  - Otherwise the IME register.
- Priority: lowest set bit of IE[4:0] & IF[4:0]; bit 0 (VBlank) highest. Vector = 0x40 + 8*index.
- FSM states:
  - IDLE: oInterrupt=0, oVector=0. On iEof with effective IME=1 and a pending source, go to DISPATCH.
  - DISPATCH: oInterrupt=1, oVector = vector latched at the transition. Stay until iIntAck=1, then go to IDLE.
- On the IDLE->DISPATCH transition, in the same edge:
  - clearmask = one-hot of the chosen index.
  - IME=0.
  - EI-pending=0.
- While in DISPATCH:
  - iEof is ignored for dispatch decisions.
  - EI/DI/RETI on iEof still update IME.
  - IF/IE writes still apply; the latched vector does not change.
- iIntAck in IDLE is ignored.

## Timing
- Reset values: IF=0, IE=0, IME=0, EI-pending=0, state=IDLE.
  - Outputs: oIf=8'hE0, oIe=0, oIme=0, oInterrupt=0, oVector=0, oWake=0.
- Reset in DISPATCH returns to IDLE on the next edge; no ack is required.
- Request pulse at cycle N: IF bit visible on oIf at N+1; oWake at N+1.
- Qualifying iEof at cycle N:
  - oInterrupt=1 and oVector valid at N+1.
  - The IF bit is cleared and oIme=0 at N+1.
- iIntAck at cycle M: oInterrupt=0 and oVector=0 at M+1. Earliest next dispatch is the next qualifying iEof at or after M+1.
- oWake and oIf are registered-state decodes; no combinational path from inputs.

## Test plan
- Reset, then IE=0x04, IME via EI then a NOP boundary, pulse iIrqTimer -> oIf=0xE4; on next iEof oInterrupt=1, oVector=0x50; IF bit 2 cleared, oIme=0; iIntAck -> oInterrupt=0, oVector=0.
- IE=0x1F, IME=1, pulse VBlank and Joypad in the same cycle -> dispatch 0x40 first; after ack and RETI boundary, dispatch 0x60.
- EI boundary with pending enabled IRQ -> no dispatch at that boundary; dispatch at the following iEof. EI then DI -> oIme stays 0, no dispatch.
- CPU writes IF=0x00 in the same cycle as an iIrqSerial pulse -> oIf=0xE8.
- IME=0, IE=0x01, VBlank pulse -> oWake=1, oInterrupt stays 0.
- iReset while in DISPATCH with oVector=0x48 -> next cycle oInterrupt=0, oVector=0, oIf=0xE0, oIe=0.
